complex_fir_stream_driver: RTL
==============================

Name: complex_fir_stream_driver

Overview:
Initiator side of the complex FIR load protocol. It holds a host-written complex coefficient set and runs the full FIR handshake: start pulse, coefficient stream, sample stream, zero-flush and stop pulse. It accepts input samples over a valid/ready handshake and drives the FIR's loadCoeff, coeffSetFlag, loadDataFlag, stopDataLoadFlag, coeffIn and dataIn inputs. It sits between the sample source and n_tap_complex_fir.

Parameters:
LENGTH, 12, number of FIR taps and coefficient entries
DATA_WIDTH, 8, coefficient width; the sample width is DATA_WIDTH*3
COEFF_SETTLE, 3, idle cycles after the last coefficient, covering the FIR coefficient pre-buffer depth
BLOCK_WIDTH, 16, width of the block-length counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
coeffWrEn  in  1  coefficient write strobe
coeffWrAddr  in  $clog2(LENGTH)  coefficient index
coeffWrRe  in  DATA_WIDTH  signed real part of the written coefficient
coeffWrIm  in  DATA_WIDTH  signed imaginary part of the written coefficient
start  in  1  begin one block
blockLength  in  BLOCK_WIDTH  number of samples in the block; sampled when start is accepted
sampleValid  in  1  source has a sample
sampleReady  out  1  driver accepts a sample this cycle
sampleInRe  in  DATA_WIDTH*3  signed sample, real part
sampleInIm  in  DATA_WIDTH*3  signed sample, imaginary part
loadCoeff  out  1  FIR start pulse
coeffSetFlag  out  1  coefficient stream complete
loadDataFlag  out  1  dataOutRe/dataOutIm hold a valid FIR input this cycle
stopDataLoadFlag  out  1  end-of-block pulse
coeffOutRe  out  DATA_WIDTH  signed coefficient to the FIR, real part
coeffOutIm  out  DATA_WIDTH  signed coefficient to the FIR, imaginary part
dataOutRe  out  DATA_WIDTH*3  signed data to the FIR, real part
dataOutIm  out  DATA_WIDTH*3  signed data to the FIR, imaginary part
busy  out  1  block in progress
done  out  1  one-cycle pulse when a block completes

Behaviour:
- Reset (asynchronous, active-high) clears every output and every coefficient register to 0 and puts the FSM in IDLE. Reset mid-block abandons the block; no stop pulse is issued.
- All outputs are registered.
- Coefficient writes take effect only in IDLE; when busy they are ignored. A write to an address >= LENGTH is ignored.
- IDLE: busy=0. On start, latch blockLength, go to START. A start while busy is ignored.
- START: loadCoeff=1 for exactly 1 cycle, then WAIT.
- WAIT: 1 cycle, which matches the FIR's own one-cycle wait state.
- COEFF: LENGTH cycles. Cycle k presents coeff[k] on coeffOutRe/coeffOutIm.
- SETTLE: COEFF_SETTLE cycles with coeffOut=0. On the last SETTLE cycle, set coeffSetFlag=1; it stays high until IDLE.
- DATA:
  - sampleReady=1.
  - Each accepted sample (sampleValid && sampleReady) appears on dataOut with loadDataFlag=1 on the next cycle.
  - A cycle with no accepted sample gives loadDataFlag=0 next cycle, and dataOut holds its last value.
  - sampleReady drops combinationally-free (registered) the cycle after the blockLength-th acceptance; no sample beyond blockLength is ever accepted.
  - blockLength=0 skips DATA entirely.
- FLUSH: LENGTH-1 cycles with dataOut=0 and loadDataFlag=1, which drains the FIR tail. This state ignores sampleValid.
- STOP: stopDataLoadFlag=1 and done=1 for 1 cycle. Clear coeffSetFlag, then return to IDLE.
- Latency from start to the first possible loadDataFlag is LENGTH+COEFF_SETTLE+3 cycles.
- Total FIR-side data beats per block = blockLength+LENGTH-1.
- Arithmetic: pass-through only, with no width change. Counters are unsigned with no wrap; the block counter compares with ==.
- Unused FSM encodings go to IDLE with all outputs cleared.

Decomposition:
- Shared package complex_fir_pkg:
  - FSM state encodings (IDLE, START, WAIT, COEFF, SETTLE, DATA, FLUSH, STOP)
  - default LENGTH/DATA_WIDTH
  - the sample width expression DATA_WIDTH*3
  This package is reused by the FIR and this driver.
- One natural sub-module: complex_coeff_regfile. It is a LENGTH-entry complex register file with a write port, a write-protect input driven by busy, asynchronous clear, and a combinational read port indexed by the COEFF counter.

Test Plan:
- Write coeff[i]=(i+1, -(i+1)) for i=0..11, then start with blockLength=4 and samples always valid: loadCoeff for 1 cycle; coeffOut shows (1,-1)..(12,-12) on 12 consecutive cycles starting 2 cycles after loadCoeff; the first loadDataFlag arrives exactly 18 cycles after start; 4 data beats then 11 zero beats; stopDataLoadFlag and done each high for one cycle.
- blockLength=3 with sampleValid toggling 1,0,1,0,1: exactly 3 samples accepted, loadDataFlag gaps mirror the valid gaps, and sampleReady=0 after the 3rd acceptance.
- blockLength=0: no sampleReady, 11 flush beats, then stop pulse.
- coeffWrEn=1 with data 7 to address 0 during DATA: coeff[0] unchanged; the next block streams the old value first. start pulsed during a block: no effect.
- Reset asserted asynchronously mid-FLUSH: all outputs 0 immediately, no stop pulse, coefficient registers 0; a new start then streams zero coefficients.
- Two back-to-back blocks with start held high: the second block begins exactly one cycle after the first done.

Source files
------------

// File: rtl/complex_fir_pkg.sv
// Shared definitions for the complex FIR and its stream driver: load-protocol
// state encodings, default geometry and the sample-width rule.
package complex_fir_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      WAIT   = 3'd2,
      COEFF  = 3'd3,
      SETTLE = 3'd4,
      DATA   = 3'd5,
      FLUSH  = 3'd6,
      STOP   = 3'd7
   } firState_e;

   localparam int DEFAULT_LENGTH       = 12;
   localparam int DEFAULT_DATA_WIDTH   = 8;
   localparam int DEFAULT_COEFF_SETTLE = 3;
   localparam int DEFAULT_BLOCK_WIDTH  = 16;

   // Samples carry three coefficient widths so products and sums stay in range.
   function automatic int sampleWidth(input int dataWidth);
      return dataWidth * 3;
   endfunction

endpackage

// File: rtl/complex_fir_stream_driver_if.sv
// Bundle of the driver's host, sample-source and FIR-side signals.
// The master modport is the driver; the slave modport is its surroundings.
interface complex_fir_stream_driver_if
   import complex_fir_pkg::*;
#(
   parameter int LENGTH      = DEFAULT_LENGTH,
   parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter int BLOCK_WIDTH = DEFAULT_BLOCK_WIDTH
);
   localparam int SAMPLE_W = sampleWidth(DATA_WIDTH);
   localparam int ADDR_W   = $clog2(LENGTH);

   logic                         coeffWrEn;
   logic        [ADDR_W-1:0]     coeffWrAddr;
   logic signed [DATA_WIDTH-1:0] coeffWrRe;
   logic signed [DATA_WIDTH-1:0] coeffWrIm;
   logic                         start;
   logic        [BLOCK_WIDTH-1:0] blockLength;
   logic                         sampleValid;
   logic                         sampleReady;
   logic signed [SAMPLE_W-1:0]   sampleInRe;
   logic signed [SAMPLE_W-1:0]   sampleInIm;
   logic                         loadCoeff;
   logic                         coeffSetFlag;
   logic                         loadDataFlag;
   logic                         stopDataLoadFlag;
   logic signed [DATA_WIDTH-1:0] coeffOutRe;
   logic signed [DATA_WIDTH-1:0] coeffOutIm;
   logic signed [SAMPLE_W-1:0]   dataOutRe;
   logic signed [SAMPLE_W-1:0]   dataOutIm;
   logic                         busy;
   logic                         done;

   modport master (
      input  coeffWrEn, coeffWrAddr, coeffWrRe, coeffWrIm,
      input  start, blockLength, sampleValid, sampleInRe, sampleInIm,
      output sampleReady, loadCoeff, coeffSetFlag, loadDataFlag, stopDataLoadFlag,
      output coeffOutRe, coeffOutIm, dataOutRe, dataOutIm, busy, done
   );

   modport slave (
      output coeffWrEn, coeffWrAddr, coeffWrRe, coeffWrIm,
      output start, blockLength, sampleValid, sampleInRe, sampleInIm,
      input  sampleReady, loadCoeff, coeffSetFlag, loadDataFlag, stopDataLoadFlag,
      input  coeffOutRe, coeffOutIm, dataOutRe, dataOutIm, busy, done
   );

endinterface

// File: rtl/complex_coeff_regfile.sv
// LENGTH-entry complex coefficient store: one write port that can be
// write-protected, asynchronous clear, and a combinational read port.
module complex_coeff_regfile
   import complex_fir_pkg::*;
#(
   parameter int LENGTH     = DEFAULT_LENGTH,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           wrEn_i,
   input  logic                           wrProtect_i,
   input  logic        [$clog2(LENGTH)-1:0] wrAddr_i,
   input  logic signed [DATA_WIDTH-1:0]   wrRe_i,
   input  logic signed [DATA_WIDTH-1:0]   wrIm_i,
   input  logic        [$clog2(LENGTH)-1:0] rdAddr_i,
   output logic signed [DATA_WIDTH-1:0]   rdRe_o,
   output logic signed [DATA_WIDTH-1:0]   rdIm_o
);

   logic signed [DATA_WIDTH-1:0] re_q [LENGTH];
   logic signed [DATA_WIDTH-1:0] im_q [LENGTH];

   logic wrHit;
   assign wrHit = wrEn_i && !wrProtect_i && (int'(wrAddr_i) < LENGTH);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LENGTH; i++) begin
            re_q[i] <= '0;
            im_q[i] <= '0;
         end
      end else if (wrHit) begin
         re_q[wrAddr_i] <= wrRe_i;
         im_q[wrAddr_i] <= wrIm_i;
      end
   end

   // Addresses past the last tap read as zero rather than aliasing an entry.
   assign rdRe_o = (int'(rdAddr_i) < LENGTH) ? re_q[rdAddr_i] : '0;
   assign rdIm_o = (int'(rdAddr_i) < LENGTH) ? im_q[rdAddr_i] : '0;

endmodule

// File: rtl/complex_fir_stream_driver.sv
// Initiator of the complex FIR load protocol: start pulse, coefficient stream,
// settle gap, sample stream with valid/ready intake, zero flush and stop pulse.
module complex_fir_stream_driver
   import complex_fir_pkg::*;
#(
   parameter int LENGTH       = DEFAULT_LENGTH,
   parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
   parameter int COEFF_SETTLE = DEFAULT_COEFF_SETTLE,
   parameter int BLOCK_WIDTH  = DEFAULT_BLOCK_WIDTH
) (
   input logic clock,
   input logic reset,
   complex_fir_stream_driver_if.master bus
);

   localparam int SAMPLE_W  = sampleWidth(DATA_WIDTH);
   localparam int ADDR_W    = $clog2(LENGTH);
   localparam int PHASE_MAX = (LENGTH > COEFF_SETTLE) ? LENGTH : COEFF_SETTLE;
   localparam int PHASE_W   = $clog2(PHASE_MAX + 1);

   localparam logic [PHASE_W-1:0] LAST_COEFF  = PHASE_W'(LENGTH - 1);
   localparam logic [PHASE_W-1:0] LAST_SETTLE = PHASE_W'(COEFF_SETTLE - 1);
   localparam logic [PHASE_W-1:0] LAST_FLUSH  = PHASE_W'(LENGTH - 2);

   firState_e                    state_q;
   logic        [PHASE_W-1:0]    phase_q;
   logic        [BLOCK_WIDTH-1:0] blockLen_q;
   logic        [BLOCK_WIDTH-1:0] accepted_q;
   logic                         loadCoeff_q;
   logic                         coeffSetFlag_q;
   logic                         loadDataFlag_q;
   logic                         stopFlag_q;
   logic                         sampleReady_q;
   logic                         busy_q;
   logic                         done_q;
   logic signed [DATA_WIDTH-1:0] coeffRe_q;
   logic signed [DATA_WIDTH-1:0] coeffIm_q;
   logic signed [SAMPLE_W-1:0]   dataRe_q;
   logic signed [SAMPLE_W-1:0]   dataIm_q;

   logic        [PHASE_W-1:0]    phaseNext;
   logic        [BLOCK_WIDTH-1:0] acceptedNext;
   logic                         accept;
   logic        [ADDR_W-1:0]     rdAddr;
   logic signed [DATA_WIDTH-1:0] rdRe;
   logic signed [DATA_WIDTH-1:0] rdIm;

   assign phaseNext    = phase_q + PHASE_W'(1);
   assign acceptedNext = accepted_q + BLOCK_WIDTH'(1);
   assign accept       = (state_q == DATA) && sampleReady_q && bus.sampleValid;

   // Read one entry ahead so the registered coeffOut lines up with the phase.
   assign rdAddr = (state_q == COEFF) ? ADDR_W'(phaseNext) : '0;

   complex_coeff_regfile #(
      .LENGTH     (LENGTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) coeffRegs (
      .clock       (clock),
      .reset       (reset),
      .wrEn_i      (bus.coeffWrEn),
      .wrProtect_i (busy_q),
      .wrAddr_i    (bus.coeffWrAddr),
      .wrRe_i      (bus.coeffWrRe),
      .wrIm_i      (bus.coeffWrIm),
      .rdAddr_i    (rdAddr),
      .rdRe_o      (rdRe),
      .rdIm_o      (rdIm)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         phase_q        <= '0;
         blockLen_q     <= '0;
         accepted_q     <= '0;
         loadCoeff_q    <= 1'b0;
         coeffSetFlag_q <= 1'b0;
         loadDataFlag_q <= 1'b0;
         stopFlag_q     <= 1'b0;
         sampleReady_q  <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         coeffRe_q      <= '0;
         coeffIm_q      <= '0;
         dataRe_q       <= '0;
         dataIm_q       <= '0;
      end else begin
         loadCoeff_q    <= 1'b0;
         loadDataFlag_q <= 1'b0;
         stopFlag_q     <= 1'b0;
         done_q         <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  blockLen_q  <= bus.blockLength;
                  busy_q      <= 1'b1;
                  loadCoeff_q <= 1'b1;
                  state_q     <= START;
               end
            end
            START: state_q <= WAIT;
            WAIT: begin
               coeffRe_q <= rdRe;
               coeffIm_q <= rdIm;
               phase_q   <= '0;
               state_q   <= COEFF;
            end
            COEFF: begin
               if (phase_q == LAST_COEFF) begin
                  coeffRe_q      <= '0;
                  coeffIm_q      <= '0;
                  phase_q        <= '0;
                  coeffSetFlag_q <= (LAST_SETTLE == '0);
                  state_q        <= SETTLE;
               end else begin
                  coeffRe_q <= rdRe;
                  coeffIm_q <= rdIm;
                  phase_q   <= phaseNext;
               end
            end
            SETTLE: begin
               if (phase_q == LAST_SETTLE) begin
                  phase_q    <= '0;
                  accepted_q <= '0;
                  if (blockLen_q == '0) begin
                     state_q <= FLUSH;
                  end else begin
                     sampleReady_q <= 1'b1;
                     state_q       <= DATA;
                  end
               end else begin
                  phase_q <= phaseNext;
                  if (phaseNext == LAST_SETTLE) coeffSetFlag_q <= 1'b1;
               end
            end
            DATA: begin
               if (accept) begin
                  dataRe_q       <= bus.sampleInRe;
                  dataIm_q       <= bus.sampleInIm;
                  loadDataFlag_q <= 1'b1;
                  accepted_q     <= acceptedNext;
                  if (acceptedNext == blockLen_q) begin
                     sampleReady_q <= 1'b0;
                     state_q       <= FLUSH;
                  end
               end
            end
            FLUSH: begin
               dataRe_q       <= '0;
               dataIm_q       <= '0;
               loadDataFlag_q <= 1'b1;
               phase_q        <= phaseNext;
               if (phase_q == LAST_FLUSH) begin
                  phase_q <= '0;
                  state_q <= STOP;
               end
            end
            STOP: begin
               stopFlag_q     <= 1'b1;
               done_q         <= 1'b1;
               coeffSetFlag_q <= 1'b0;
               busy_q         <= 1'b0;
               state_q        <= IDLE;
            end
            default: begin
               state_q        <= IDLE;
               phase_q        <= '0;
               accepted_q     <= '0;
               coeffSetFlag_q <= 1'b0;
               sampleReady_q  <= 1'b0;
               busy_q         <= 1'b0;
               coeffRe_q      <= '0;
               coeffIm_q      <= '0;
               dataRe_q       <= '0;
               dataIm_q       <= '0;
            end
         endcase
      end
   end

   assign bus.sampleReady      = sampleReady_q;
   assign bus.loadCoeff        = loadCoeff_q;
   assign bus.coeffSetFlag     = coeffSetFlag_q;
   assign bus.loadDataFlag     = loadDataFlag_q;
   assign bus.stopDataLoadFlag = stopFlag_q;
   assign bus.coeffOutRe       = coeffRe_q;
   assign bus.coeffOutIm       = coeffIm_q;
   assign bus.dataOutRe        = dataRe_q;
   assign bus.dataOutIm        = dataIm_q;
   assign bus.busy             = busy_q;
   assign bus.done             = done_q;

endmodule
